// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath serializer/deserializer pair.
package fir_pkg;

    // Default sample width shared by serializer and deserializer.
    localparam int unsigned SAMPLE_WIDTH = 24;

    // One-hot FSM state encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_HOLD  = 3'b100
    } state_t;

endpackage

// File: rtl/deserializer_fsm_if.sv
// Bit-stream input and word output handshakes of the deserializer.
// master: the surrounding logic (bit source and word sink); slave: the deserializer.
interface deserializer_fsm_if
    import fir_pkg::*;
#(
    parameter int unsigned LENGTH = SAMPLE_WIDTH
) ();

    logic              i_din;
    logic              i_din_valid;
    logic              o_ready;
    logic [LENGTH-1:0] ov_dout;
    logic              o_dout_valid;
    logic              i_ready;

    modport master (
        output i_din,
        output i_din_valid,
        output i_ready,
        input  o_ready,
        input  ov_dout,
        input  o_dout_valid
    );

    modport slave (
        input  i_din,
        input  i_din_valid,
        input  i_ready,
        output o_ready,
        output ov_dout,
        output o_dout_valid
    );

endinterface

// File: rtl/deserializer_bit_counter.sv
// Counts accepted bits of the word being assembled; tc flags the last bit position.
module deserializer_bit_counter
    import fir_pkg::*;
#(
    parameter int unsigned LENGTH = SAMPLE_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

    logic [CNT_W-1:0] cnt;

    // Clear wins over increment so the last bit of a word restarts the count at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/deserializer_fsm.sv
// Serial-to-parallel stage: assembles LENGTH bits from a valid/ready bit stream
// into a word presented through a second valid/ready handshake.
// Build option: DESERIALIZER_MSB_FIRST_EN selects MSB-first assembly
// (default is LSB-first, matching the FIR word serializer).
module deserializer_fsm
    import fir_pkg::*;
#(
    parameter int unsigned LENGTH = SAMPLE_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    deserializer_fsm_if.slave  bus
);

    state_t            state;
    logic [LENGTH-1:0] sreg;
    logic [LENGTH-1:0] sreg_next;
    logic              xfer;
    logic              last_bit;

    assign bus.o_ready = i_en && (state == S_SHIFT);
    assign xfer        = bus.o_ready && bus.i_din_valid;

    // Shift register value after accepting the current bit.
    always_comb begin
`ifdef DESERIALIZER_MSB_FIRST_EN
        sreg_next = {sreg[LENGTH-2:0], bus.i_din};
`else
        sreg_next = {bus.i_din, sreg[LENGTH-1:1]};
`endif
    end

    deserializer_bit_counter #(
        .LENGTH (LENGTH)
    ) u_bit_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clear (xfer && last_bit),
        .inc   (xfer),
        .tc    (last_bit)
    );

    // FSM with shift register and registered word outputs; reset beats enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            sreg             <= '0;
            bus.ov_dout      <= '0;
            bus.o_dout_valid <= 1'b0;
        end else if (i_en) begin
            case (state)
                S_IDLE: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bus.i_din_valid) begin
                        sreg <= sreg_next;
                        if (last_bit) begin
                            bus.ov_dout      <= sreg_next;
                            bus.o_dout_valid <= 1'b1;
                            state            <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // ov_dout is left untouched so it keeps the last word after acceptance.
                    if (bus.i_ready) begin
                        bus.o_dout_valid <= 1'b0;
                        state            <= S_SHIFT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Directed self-checking bench for deserializer_fsm (LENGTH = 24).
// Honours DESERIALIZER_MSB_FIRST_EN for the expected word values.
module tb_deserializer_fsm;
    import fir_pkg::*;

    localparam int unsigned LEN    = 24;
    localparam int          PERIOD = 10;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_en;

    int checks = 0;
    int errors = 0;

    deserializer_fsm_if #(.LENGTH(LEN)) bus ();

    deserializer_fsm #(
        .LENGTH (LEN)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .bus   (bus)
    );

    always #(PERIOD / 2) i_clk = ~i_clk;

    // Word as it should appear on ov_dout when w is sent LSB first.
    function automatic logic [23:0] exp_word(input logic [23:0] w);
        logic [23:0] r;
`ifdef DESERIALIZER_MSB_FIRST_EN
        for (int k = 0; k < 24; k++) r[23-k] = w[k];
`else
        r = w;
`endif
        return r;
    endfunction

    // Drive bits lo..hi-1 of word LSB first; bits advance only on a completed handshake.
    task automatic send_bits(input logic [23:0] word, input int lo, input int hi,
                             input bit gapped, output int cycles, output int valid_seen,
                             output time first_t);
        int idx;
        bit v;
        idx        = lo;
        v          = 1'b1;
        cycles     = 0;
        valid_seen = 0;
        first_t    = 0;
        while (idx < hi && cycles < 200) begin
            @(negedge i_clk);
            i_en            = 1'b1;
            bus.i_din       = word[idx];
            bus.i_din_valid = gapped ? v : 1'b1;
            v               = ~v;
            #1;
            if (bus.o_dout_valid) valid_seen++;
            if (bus.o_ready && bus.i_din_valid) begin
                if (idx == lo) first_t = $time;
                idx++;
            end
            cycles++;
        end
        checks++;
        if (idx != hi) begin
            errors++;
            $display("FAIL send_bits_timeout: sent %0d bits, required %0d", idx - lo, hi - lo);
        end
    endtask

    task automatic test_reset();
        i_rst           = 1'b1;
        i_en            = 1'b1;
        bus.i_din       = 1'b0;
        bus.i_din_valid = 1'b0;
        bus.i_ready     = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", bus.o_dout_valid);
        end
        checks++;
        if (bus.ov_dout !== 24'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h, required 000000", bus.ov_dout);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b, required 0", bus.o_ready);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_ready: got %b, required 1", bus.o_ready);
        end
    endtask

    task automatic test_continuous();
        int  c1, c2, v1, v2;
        time t1, t2;
        bus.i_ready = 1'b1;
        send_bits(24'hA5C3F0, 0, 24, 1'b0, c1, v1, t1);
        checks++;
        if (c1 != 24) begin
            errors++;
            $display("FAIL cont_cycles: got %0d, required 24", c1);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(24'hA5C3F0)) begin
            errors++;
            $display("FAIL cont_word: got valid=%b dout=%h, required valid=1 dout=%h",
                     bus.o_dout_valid, bus.ov_dout, exp_word(24'hA5C3F0));
        end
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready: got %b, required 0", bus.o_ready);
        end
        send_bits(24'h000001, 0, 24, 1'b0, c2, v2, t2);
        checks++;
        if (v2 != 0) begin
            errors++;
            $display("FAIL valid_one_cycle: extra valid cycles %0d, required 0", v2);
        end
        checks++;
        if ((t2 - t1) != 25 * PERIOD) begin
            errors++;
            $display("FAIL word_period: got %0d cycles, required 25", (t2 - t1) / PERIOD);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(24'h000001)) begin
            errors++;
            $display("FAIL b2b_word: got valid=%b dout=%h, required valid=1 dout=%h",
                     bus.o_dout_valid, bus.ov_dout, exp_word(24'h000001));
        end
    endtask

    task automatic test_backpressure();
        int  c, vs, bad;
        time t;
        @(negedge i_clk);
        bus.i_din_valid = 1'b0;
        bus.i_ready     = 1'b0;
        send_bits(24'h123456, 0, 24, 1'b0, c, vs, t);
        bad = 0;
        repeat (5) begin
            @(negedge i_clk);
            bus.i_din_valid = 1'b1;
            #1;
            if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(24'h123456) ||
                bus.o_ready !== 1'b0 || dut.u_bit_counter.cnt !== 5'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: unstable cycles %0d, required 0", bad);
        end
        @(negedge i_clk);
        bus.i_ready     = 1'b1;
        bus.i_din_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got ready=%b valid=%b, required ready=0 valid=1",
                     bus.o_ready, bus.o_dout_valid);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_dout_valid !== 1'b0 ||
            bus.ov_dout !== exp_word(24'h123456)) begin
            errors++;
            $display("FAIL bp_after: got ready=%b valid=%b dout=%h, required 1 0 %h",
                     bus.o_ready, bus.o_dout_valid, bus.ov_dout, exp_word(24'h123456));
        end
    endtask

    task automatic test_gapped();
        int  c, vs;
        time t;
        send_bits(24'hFFFFFF, 0, 24, 1'b1, c, vs, t);
        checks++;
        if (c != 47) begin
            errors++;
            $display("FAIL gap_cycles: got %0d, required 47", c);
        end
        @(negedge i_clk);
        bus.i_din_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(24'hFFFFFF)) begin
            errors++;
            $display("FAIL gap_word: got valid=%b dout=%h, required valid=1 dout=%h",
                     bus.o_dout_valid, bus.ov_dout, exp_word(24'hFFFFFF));
        end
    endtask

    task automatic test_reset_mid_word();
        int  c, vs;
        time t;
        send_bits(24'h0003FF, 0, 10, 1'b0, c, vs, t);
        @(negedge i_clk);
        i_rst           = 1'b1;
        bus.i_din_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b0 || bus.ov_dout !== 24'h0 ||
            dut.u_bit_counter.cnt !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b dout=%h cnt=%0d, required 0 000000 0",
                     bus.o_dout_valid, bus.ov_dout, dut.u_bit_counter.cnt);
        end
        send_bits(24'h000001, 0, 24, 1'b0, c, vs, t);
        checks++;
        if (c != 24 || vs != 0) begin
            errors++;
            $display("FAIL rst_resume: got cycles=%0d valid=%0d, required 24 0", c, vs);
        end
        @(negedge i_clk);
        bus.i_din_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(24'h000001)) begin
            errors++;
            $display("FAIL rst_word: got valid=%b dout=%h, required valid=1 dout=%h",
                     bus.o_dout_valid, bus.ov_dout, exp_word(24'h000001));
        end
    endtask

    task automatic test_enable_stall();
        int          c, vs, bad;
        time         t;
        logic [23:0] w;
        w = 24'hABCDEF;
        send_bits(w, 0, 12, 1'b0, c, vs, t);
        bad = 0;
        repeat (4) begin
            @(negedge i_clk);
            i_en            = 1'b0;
            bus.i_din       = w[12];
            bus.i_din_valid = 1'b1;
            #1;
            if (bus.o_ready !== 1'b0 || dut.u_bit_counter.cnt !== 5'd12 ||
                bus.o_dout_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_stall: bad cycles %0d, required 0", bad);
        end
        send_bits(w, 12, 24, 1'b0, c, vs, t);
        checks++;
        if (c != 12) begin
            errors++;
            $display("FAIL en_resume: got %0d cycles, required 12", c);
        end
        @(negedge i_clk);
        bus.i_din_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_dout_valid !== 1'b1 || bus.ov_dout !== exp_word(w)) begin
            errors++;
            $display("FAIL en_word: got valid=%b dout=%h, required valid=1 dout=%h",
                     bus.o_dout_valid, bus.ov_dout, exp_word(w));
        end
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_gapped();
        test_reset_mid_word();
        test_enable_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializer_fsm.md
# deserializer_fsm

Serial-to-parallel stage of the FIR filter datapath. It accepts a 1-bit stream through a valid/ready handshake, assembles `LENGTH` bits into a word, and presents that word downstream through a second valid/ready handshake. It sits directly downstream of the FIR word serializer and reassembles its LSB-first bit stream into sample words for the next stage.

## Interface
- `LENGTH`, 24, word width in bits; must be at least 2.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high. The clock is `i_clk`.
- `i_en`  in  1  clock enable. When low, every register holds and no handshake completes.
- `i_din`  in  1  serial data bit.
- `i_din_valid`  in  1  upstream bit is valid.
- `o_ready`  out  1  block accepts a bit this cycle. Combinational: `i_en && state==S_SHIFT`.
- `ov_dout`  out  LENGTH  assembled word. Registered; reset value 0.
- `o_dout_valid`  out  1  `ov_dout` is valid. Registered; reset value 0.
- `i_ready`  in  1  downstream accepts the word.

## Operation
- State register: one-hot encoding, states S_IDLE, S_SHIFT and S_HOLD. Reset state is S_IDLE. An unreachable encoding returns to S_IDLE.
- S_IDLE → S_SHIFT on the first cycle with `i_en`. `o_ready` is 0 while in S_IDLE.
- A bit transfer occurs on a rising edge where `i_en && o_ready && i_din_valid` holds.
- Bit transfer behaviour:
  - The shift register (width LENGTH) takes `{i_din, sreg[LENGTH-1:1]}`, so the bit order is LSB first.
  - The bit counter increments.
  - The counter width is `$clog2(LENGTH)` and its range is 0..LENGTH-1.
- Transfer with counter == LENGTH-1 (the last bit):
  - `ov_dout` takes the completed word, with the final bit in the MSB.
  - `o_dout_valid` goes to 1.
  - The counter goes to 0.
  - The state goes to S_HOLD.
- S_SHIFT with `i_din_valid` low: nothing changes. Gaps of any length are allowed between bits.
- S_HOLD:
  - `o_ready` = 0.
  - `ov_dout` and `o_dout_valid` are held stable until the word is accepted.
  - A word is accepted on an edge with `i_en && i_ready`. At that edge the state goes to S_SHIFT and `o_dout_valid` goes to 0.
  - `ov_dout` keeps its last value after acceptance.
- Both handshakes follow the same rule: the consumer may assert ready before valid, and a transfer needs both signals high on the same edge.
- Reset at any point:
  - The state returns to S_IDLE.
  - The counter, the shift register, `ov_dout` and `o_dout_valid` are cleared.
  - Partial words are discarded with no output.
- `i_en` low: nothing changes in the block, and `o_ready` is 0. `o_dout_valid` keeps its value but the word is not consumed.
- `i_rst` takes priority over `i_en`.

## Timing
- Latency: `o_dout_valid` is high in the cycle right after the edge that transfers the last bit.
- Minimum period is LENGTH+1 cycles per word: LENGTH bit transfers plus one S_HOLD cycle with `i_ready` high.
- After a word is accepted, `o_ready` is high in the next cycle.
- After reset deasserts, the first `o_ready` appears one cycle later, because S_IDLE lasts one enabled cycle.
- While in S_HOLD, upstream `i_din_valid` can stay high indefinitely and no bit is consumed.

## Configuration
- Macro: `DESERIALIZER_MSB_FIRST_EN`.
- Undefined: LSB-first assembly, `sreg <= {i_din, sreg[LENGTH-1:1]}`. This matches the serializer.
- Defined: MSB-first assembly, `sreg <= {sreg[LENGTH-2:0], i_din}`. The first received bit ends in the MSB.
- Handshake, timing and reset behaviour are identical in both builds.

## Structure
- The shared package `fir_pkg` holds:
  - the one-hot state constants S_IDLE, S_SHIFT and S_HOLD;
  - the default sample width constant (24), which both serializer and deserializer use.
- One sub-module, `deserializer_bit_counter`:
  - parameter LENGTH;
  - inputs: clear, increment enable;
  - output: terminal-count flag, high when the count equals LENGTH-1.
- The FSM, the shift register and the output registers stay in `deserializer_fsm`.

## Test plan
- Continuous stream:
  - Stimulus: LENGTH=24, 0xA5C3F0 sent LSB first, `i_din_valid` high continuously, `i_ready` high.
  - Response: `ov_dout`=0xA5C3F0, with `o_dout_valid` high for exactly one cycle, starting the cycle after the 24th transfer.
  - Then 0x000001 is sent back to back and the next word starts 25 cycles after the first.
- Backpressure:
  - Stimulus: `i_ready` held low for 5 cycles in S_HOLD.
  - Response: `o_dout_valid` and `ov_dout` (0x123456) stay stable, `o_ready`=0 and no bits are consumed.
  - After `i_ready` rises, `o_ready` returns one cycle later.
- Gapped input:
  - Stimulus: `i_din_valid` toggles 1/0 every cycle while sending 0xFFFFFF.
  - Response: 24 transfers over 47 cycles and output 0xFFFFFF.
- Reset mid-word:
  - Stimulus: `i_rst` pulsed after 10 bits of 0x3FF, then 0x000001 sent.
  - Response: during reset `o_dout_valid`=0 and `ov_dout`=0; the next output is exactly 0x000001.
- Enable stall:
  - Stimulus: `i_en` low for 4 cycles mid-word while `i_din_valid`=1.
  - Response: `o_ready`=0, the counter holds, and the final word 0xABCDEF is correct.
- MSB-first build (`DESERIALIZER_MSB_FIRST_EN` defined):
  - Stimulus: the same serial sequence as in the first test.
  - Response: output 0x0FC3A5, the bit reversal of 0xA5C3F0.
